// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes, imported by storage, read-port and mux-tree modules.
package regfile_pkg;

   localparam int unsigned REG_COUNT = 32;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DATA_W    = 64;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_word_t;

   localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_storage_decoder.sv
// Gated 5:32 one-hot write decoder built from a 2:4 and a 3:8 decoder in gate form.
module decoder_5_32
   import regfile_pkg::REG_COUNT;
   import regfile_pkg::reg_addr_t;
(
   input  logic                 enable,
   input  reg_addr_t            sel,
   output logic [REG_COUNT-1:0] onehot
);

   logic [3:0] hi;
   logic [7:0] lo;

   // The enable gates the high decoder so the whole output is zero when idle.
   assign hi[0] = enable & ~sel[4] & ~sel[3];
   assign hi[1] = enable & ~sel[4] &  sel[3];
   assign hi[2] = enable &  sel[4] & ~sel[3];
   assign hi[3] = enable &  sel[4] &  sel[3];

   assign lo[0] = ~sel[2] & ~sel[1] & ~sel[0];
   assign lo[1] = ~sel[2] & ~sel[1] &  sel[0];
   assign lo[2] = ~sel[2] &  sel[1] & ~sel[0];
   assign lo[3] = ~sel[2] &  sel[1] &  sel[0];
   assign lo[4] =  sel[2] & ~sel[1] & ~sel[0];
   assign lo[5] =  sel[2] & ~sel[1] &  sel[0];
   assign lo[6] =  sel[2] &  sel[1] & ~sel[0];
   assign lo[7] =  sel[2] &  sel[1] &  sel[0];

   for (genvar i = 0; i < 4; i++) begin : gen_hi
      for (genvar j = 0; j < 8; j++) begin : gen_lo
         assign onehot[8*i+j] = hi[i] & lo[j];
      end
   end

endmodule

// File: rtl/regfile_storage.sv
// 32-entry register-file storage: one synchronous write per cycle, contents presented
// bit-sliced for the per-bit 32:1 read mux tree. The zero register is hardwired to 0.
module regfile_storage
   import regfile_pkg::REG_COUNT;
   import regfile_pkg::ADDR_W;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            RegWrite,
   input  logic [ADDR_W-1:0]               WriteRegister,
   input  logic [DATA_W-1:0]               WriteData,
   output logic [DATA_W-1:0][REG_COUNT-1:0] reg_slices,
   output logic [31:0]                     write_count
);

   localparam logic [REG_COUNT-1:0] ZERO_MASK = REG_COUNT'(1) << ZERO_REG;

   logic [REG_COUNT-1:0] wr_en_c;
   logic                 commit_c;

   decoder_5_32 u_dec (
      .enable (RegWrite),
      .sel    (WriteRegister),
      .onehot (wr_en_c)
   );

   // A write aimed at the zero register is not a commit.
   assign commit_c = |(wr_en_c & ~ZERO_MASK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_count <= 32'd0;
      end else if (commit_c) begin
         write_count <= write_count + 32'd1;
      end
   end

   for (genvar r = 0; r < REG_COUNT; r++) begin : gen_reg
      logic [DATA_W-1:0] q;

      if (r == ZERO_REG) begin : gen_zero
         assign q = '0;
      end else begin : gen_flop
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               q <= '0;
            end else if (wr_en_c[r]) begin
               q <= WriteData;
            end
         end
      end

      // Pure rewiring: bit b of register r lands on slice b, lane r.
      for (genvar b = 0; b < DATA_W; b++) begin : gen_bit
         assign reg_slices[b][r] = q[b];
      end
   end

endmodule

// File: tb/tb_regfile_storage.sv
// Scoreboarded random/directed bench for regfile_storage against an array-based register model.
module tb_regfile_storage;

   localparam int unsigned DW = 64;
   localparam int unsigned NR = 32;

   typedef struct packed {
      logic [NR-1:0][DW-1:0] regs;
      logic [31:0]           cnt;
      logic [7:0]            tag;
   } snap_t;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    RegWrite = 1'b0;
   logic [4:0]              WriteRegister = 5'd0;
   logic [DW-1:0]           WriteData = '0;
   logic [DW-1:0][NR-1:0]   reg_slices;
   logic [31:0]             write_count;

   regfile_storage #(.DATA_W(64), .ZERO_REG(31)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .reg_slices    (reg_slices),
      .write_count   (write_count)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] m_regs [NR];
   logic [31:0]   m_cnt;
   snap_t         sb_q [$];
   int            vectors = 0;
   int            miscompares = 0;

   // 32:1 read per bit, as the downstream mux tree would do it.
   function automatic logic [DW-1:0] read_reg(input int r);
      logic [DW-1:0] v;
      for (int b = 0; b < DW; b++) v[b] = reg_slices[b][r];
      return v;
   endfunction

   task automatic push_exp(input logic [7:0] tag);
      snap_t s;
      for (int r = 0; r < NR; r++) s.regs[r] = m_regs[r];
      s.cnt = m_cnt;
      s.tag = tag;
      sb_q.push_back(s);
   endtask

   task automatic model_clear();
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_cnt = 32'd0;
   endtask

   task automatic model_write(input logic we, input logic [4:0] a, input logic [DW-1:0] d);
      if (we && a != 5'd31) begin
         m_regs[a] = d;
         m_cnt     = m_cnt + 32'd1;
      end
   endtask

   // One clocked write request; expectation pushed after the edge.
   task automatic cycle(input logic we, input logic [4:0] a, input logic [DW-1:0] d,
                        input logic [7:0] tag);
      @(negedge clk);
      RegWrite = we;
      WriteRegister = a;
      WriteData = d;
      @(posedge clk);
      #1;
      model_write(we, a, d);
      push_exp(tag);
   endtask

   // Monitor: compare the whole register file and counter once per cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            snap_t s;
            int bad;
            s = sb_q.pop_front();
            bad = -1;
            for (int r = NR - 1; r >= 0; r--)
               if (read_reg(r) !== s.regs[r]) bad = r;
            vectors++;
            if (bad >= 0) begin
               miscompares++;
               $display("FAIL regs tag=%0d X%0d got=%h exp=%h", s.tag, bad, read_reg(bad),
                        s.regs[bad]);
            end
            vectors++;
            if (write_count !== s.cnt) begin
               miscompares++;
               $display("FAIL write_count tag=%0d got=%0d exp=%0d", s.tag, write_count, s.cnt);
            end
         end
      end
   end

   initial begin
      model_clear();
      push_exp(8'd0);                 // reset state, checked at first negedge
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;

      // Random state, then asynchronous reset between edges.
      for (int i = 0; i < 40; i++)
         cycle(1'($urandom), 5'($urandom), {$urandom, $urandom}, 8'd1);
      @(posedge clk);
      #2;
      RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = '1;
      reset_n = 1'b0;
      model_clear();
      push_exp(8'd2);
      @(negedge clk);
      #1 reset_n = 1'b1;
      RegWrite = 1'b0;

      cycle(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 8'd3);
      cycle(1'b1, 5'd31, '1, 8'd4);
      cycle(1'b1, 5'd7, 64'h0000_0000_0000_0777, 8'd5);
      cycle(1'b0, 5'd7, '1, 8'd6);

      // Write-then-read on X3 in consecutive cycles.
      cycle(1'b1, 5'd3, 64'h1, 8'd7);
      cycle(1'b1, 5'd3, 64'h2, 8'd8);
      cycle(1'b0, 5'd3, 64'h0, 8'd9);

      for (int r = 0; r < 32; r++)
         cycle(1'b1, 5'(r), 64'(r), 8'd10);

      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), 5'($urandom), {$urandom, $urandom}, 8'd11);

      // Reset mid-cycle with an X10 write held across release.
      @(posedge clk);
      #2;
      RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'hA5A5_0000_1234_5678;
      #1 reset_n = 1'b0;
      model_clear();
      push_exp(8'd12);
      @(negedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      model_write(1'b1, 5'd10, 64'hA5A5_0000_1234_5678);
      push_exp(8'd13);
      cycle(1'b0, 5'd0, '0, 8'd14);

      for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d exp=0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_storage.md
# regfile_storage

Storage array of the 32 x 64-bit LEGv8 register file. It holds the architectural registers, performs the single synchronous write per cycle through a gated 5:32 write decoder, and presents the stored contents bit-sliced. Each output slice is one 32-bit vector per data bit, indexed by register number. That is the exact form the downstream per-bit 32:1 read-port mux tree consumes. Register X31 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 64, register width in bits; one read-mux slice per bit.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset_n, input, 1, reset, asynchronous, active-low; clears every register.
- RegWrite, input, 1, write enable for the current cycle.
- WriteRegister, input, 5, destination register index.
- WriteData, input, DATA_W, value to write.
- reg_slices, output, [DATA_W-1:0][31:0], reg_slices[b][r] = bit b of register r. Slice b connects directly to the input_read of read mux b.
- write_count, output, 32, number of committed writes since reset; wraps modulo 2^32. Used for bench and debug visibility.

## Operation
- 32 registers, each DATA_W flip-flops with a per-register enable.
- Decoder: when RegWrite=1, drives a one-hot 32-bit enable from WriteRegister. When RegWrite=0, the enable is all-zero.
- Commit: at the rising edge with RegWrite=1 and WriteRegister!=ZERO_REG, register[WriteRegister] <= WriteData.
- The write_count increments by 1 on each commit. It wraps from 0xFFFF_FFFF to 0.
- Write to ZERO_REG: the register stays 0, no commit occurs, and write_count is unchanged.
- RegWrite=0: no state changes; WriteRegister and WriteData are don't-care.
- Outputs: reg_slices is a pure rewiring of the register flops, with no logic between the flops and the ports. reg_slices[b][ZERO_REG] is constant 0.
- No read-after-write bypass. A read in the same cycle as a write to the same register sees the old value, and the new value is visible from the next cycle. Any bypass belongs to the pipeline's forwarding logic, not to this block.

## Timing
- Write latency: 1 edge. The value is captured at edge N and visible on reg_slices after edge N plus clk-to-q.
- Read path: reg_slices changes only after a clock edge or reset, never combinationally from the write inputs.
- Reset: when reset_n falls, all registers and write_count go to 0 immediately, with no clock needed.
- While reset_n is low, edges are ignored, including any in-flight write.
- A write request held across reset deassertion commits at the first rising edge after reset_n rises.
- Reset asserted mid-cycle between edges cancels any pending write entirely. There is no partial or late commit.
- Output reset values: reg_slices = all 0 and write_count = 0.
- The flop primitive is a DFF with asynchronous active-low clear; the #50 ps gate-delay style of the codebase applies to the decoder gates.

## Structure
- Shared package regfile_pkg:
  - REG_COUNT = 32, ADDR_W = 5, DATA_W = 64, ZERO_REG = 5'd31.
  - typedef reg_addr_t (logic [ADDR_W-1:0]).
  - typedef reg_word_t (logic [DATA_W-1:0]).
  - These are also imported by the read-port and mux-tree modules.
- Sub-module decoder_5_32:
  - Inputs: enable and 5-bit select. Output: 32-bit one-hot.
  - Built from 2:4 and 3:8 decoders in gate form.
  - Instantiated once.
- Registers are produced by a generate loop of enabled 64-bit registers. Slot ZERO_REG is tied to constant 0 instead of a register.

## Test plan
- Reset: drive reset_n=0 with random state present -> all reg_slices bits are 0 and write_count=0 before any clock edge.
- Single write: RegWrite=1, WriteRegister=5, WriteData=0xDEAD_BEEF_0123_4567, one edge -> reg_slices[b][5] matches the data bits for all b, the other registers are unchanged, and write_count=1.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=all-ones -> reg_slices[b][31]=0 for all b and write_count is unchanged.
- Enable low: RegWrite=0, WriteRegister=7, WriteData=0xFFFF_FFFF_FFFF_FFFF -> register 7 keeps its prior value and write_count is unchanged.
- Write then read: write 0x1 to X3 at edge N and 0x2 to X3 at edge N+1 -> the X3 slice reads the old value before N, 0x1 between N and N+1, and 0x2 after. Then write all 31 writable registers with their index and read each back through an attached mux_32_1 per bit -> each register reads its index.
- Reset mid-operation: assert reset_n=0 between edges while a write to X10 is requested, and release it before the next edge with the request held -> X10 is 0 during reset and commits at the first edge after release; write_count=1.
